// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU op
// codes, FSM state encoding and the per-state control word.
package multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_EXEC_R,
    S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_HALT, S_ERROR
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwrite_cond;
    logic       invertzero;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [3:0] aluop;
    logic       rtype;
    logic [1:0] pcsource;
    logic       halted;
    logic       error;
  } ctrl_t;

  function automatic state_t decode_next(input logic [31:0] ir);
    if (ir == 32'h0) return S_HALT;
    case (ir[31:26])
      OP_R:                     return S_EXEC_R;
      OP_LW, OP_SW:             return S_ADDR;
      OP_ADDI, OP_ANDI, OP_ORI: return S_EXEC_I;
      OP_BEQ, OP_BNE:           return S_BRANCH;
      OP_J:                     return S_JUMP;
      default:                  return S_ERROR;
    endcase
  endfunction

  // Moore control word; FETCH's irwrite/pcwrite are gated on mem_ready in the top.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.memread = 1'b1; c.alusrc_b = 2'b01; c.aluop = ALU_ADD; end
      S_DECODE: begin c.alusrc_b = 2'b11; c.aluop = ALU_ADD; end
      S_ADDR:   begin c.alusrc_a = 1'b1; c.alusrc_b = 2'b10; c.aluop = ALU_ADD; end
      S_MEM_RD: begin c.iord = 1'b1; c.memread = 1'b1; end
      S_MEM_WR: begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_WB_MEM: begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_EXEC_R: begin c.alusrc_a = 1'b1; c.aluop = ALU_FUNCT; c.rtype = 1'b1; end
      S_WB_R:   begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_EXEC_I: begin
        c.alusrc_b = 2'b10;
        c.aluop = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_WB_I:   c.regwrite = 1'b1;
      S_BRANCH: begin
        c.alusrc_a = 1'b1; c.aluop = ALU_SUB; c.pcwrite_cond = 1'b1;
        c.pcsource = 2'b01; c.invertzero = (op == OP_BNE);
      end
      S_JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      S_HALT:   c.halted = 1'b1;
      S_ERROR:  c.error = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; timeout flags the last allowed cycle.
module mem_wait_timer #(
  parameter int LIMIT = 16,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (clear)                  cnt <= '0;
    else if (enable && !timeout) cnt <= cnt + 1'b1;
  end

  // The LIMIT-th consecutive wait cycle is the last chance for mem_ready.
  assign timeout = (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory handshake/timeout, halt, sticky
// error and a retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        instruction,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwrite_cond,
  output logic               invertzero,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic [ALUOP_W-1:0] aluop,
  output logic               rtype,
  output logic [1:0]         pcsource,
  output logic               halted,
  output logic               error,
  output logic [CNT_W-1:0]   retired
);
  state_t state, nxt;
  ctrl_t  ctrl;
  logic   in_wait, timeout, retire;

  // zero is consumed by the datapath's conditional PC-write gate, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .clear   (reset || !in_wait || (nxt != state)),
    .enable  (in_wait && !mem_ready),
    .timeout (timeout)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE; else if (timeout) nxt = S_ERROR;
      S_DECODE: nxt = decode_next(instruction);
      S_ADDR:   nxt = (instruction[31:26] == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) nxt = S_WB_MEM; else if (timeout) nxt = S_ERROR;
      S_MEM_WR: if (mem_ready) nxt = S_FETCH;  else if (timeout) nxt = S_ERROR;
      S_EXEC_R: nxt = S_WB_R;
      S_EXEC_I: nxt = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: nxt = S_FETCH;
      default:  nxt = state;
    endcase
  end

  assign retire = (state == S_WB_MEM) || (state == S_WB_R) || (state == S_WB_I) ||
                  (state == S_BRANCH) || (state == S_JUMP) ||
                  ((state == S_MEM_WR) && mem_ready);

  // Control word is registered from the next state so outputs stay Moore.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_FETCH;
      ctrl    <= state_ctrl(S_FETCH, 6'h0);
      retired <= '0;
    end else begin
      state <= nxt;
      ctrl  <= state_ctrl(nxt, instruction[31:26]);
      if (retire) retired <= retired + 1'b1;
    end
  end

  assign irwrite      = (state == S_FETCH) && mem_ready;
  assign pcwrite      = ctrl.pcwrite || irwrite;
  assign pcwrite_cond = ctrl.pcwrite_cond;
  assign invertzero   = ctrl.invertzero;
  assign iord         = ctrl.iord;
  assign memread      = ctrl.memread;
  assign memwrite     = ctrl.memwrite;
  assign regdst       = ctrl.regdst;
  assign memtoreg     = ctrl.memtoreg;
  assign regwrite     = ctrl.regwrite;
  assign alusrc_a     = ctrl.alusrc_a;
  assign alusrc_b     = ctrl.alusrc_b;
  assign aluop        = ALUOP_W'(ctrl.aluop);
  assign rtype        = ctrl.rtype;
  assign pcsource     = ctrl.pcsource;
  assign halted       = ctrl.halted;
  assign error        = ctrl.error;
endmodule
